// File: rtl/array_mult_pipelined_hs.sv
// Pipelined Baugh-Wooley array multiplier with valid/ready handshake and sideband.
// Carry-save row stages (ROWS_PER_STAGE rows each) feed a registered final adder.

module array_mult_pipelined_hs_stage #(
  parameter int WIDTH = 8,
  parameter int CW    = 4,
  parameter int LO    = 0,
  parameter int HI    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               vld_i,
  input  logic [2*WIDTH-1:0] s_i,
  input  logic [2*WIDTH-1:0] c_i,
  input  logic [WIDTH-1:0]   x_i,
  input  logic [WIDTH-1:0]   y_i,
  input  logic               m_i,
  input  logic [CW-1:0]      ctl_i,
  output logic               vld_o,
  output logic [2*WIDTH-1:0] s_o,
  output logic [2*WIDTH-1:0] c_o,
  output logic [WIDTH-1:0]   x_o,
  output logic [WIDTH-1:0]   y_o,
  output logic               m_o,
  output logic [CW-1:0]      ctl_o
);
  logic [2*WIDTH-1:0] s_n, c_n, r, t;

  // Signed mode inverts the MSB row and MSB column, but not their shared corner bit.
  function automatic logic [2*WIDTH-1:0] pp_row(input int i, input logic [WIDTH-1:0] xv,
                                                input logic [WIDTH-1:0] yv, input logic m);
    logic [2*WIDTH-1:0] row;
    row = '0;
    for (int j = 0; j < WIDTH; j++)
      row[i+j] = (xv[j] & yv[i]) ^ (m & ((i == WIDTH-1) != (j == WIDTH-1)));
    return row;
  endfunction

  always_comb begin
    s_n = s_i;
    c_n = c_i;
    r   = '0;
    t   = '0;
    for (int i = LO; i <= HI; i++) begin
      r   = pp_row(i, x_i, y_i, m_i);
      t   = s_n ^ c_n ^ r;
      c_n = ((s_n & c_n) | (s_n & r) | (c_n & r)) << 1;
      s_n = t;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_o <= 1'b0;
      s_o   <= '0;
      c_o   <= '0;
      x_o   <= '0;
      y_o   <= '0;
      m_o   <= 1'b0;
      ctl_o <= '0;
    end else if (en) begin
      vld_o <= vld_i;
      s_o   <= s_n;
      c_o   <= c_n;
      x_o   <= x_i;
      y_o   <= y_i;
      m_o   <= m_i;
      ctl_o <= ctl_i;
    end
  end
endmodule

module array_mult_pipelined_hs #(
  parameter int WIDTH                 = 8,
  parameter int ROWS_PER_STAGE        = 1,
  parameter int CONTROL_SIGNALS_WIDTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [WIDTH-1:0]                 x,
  input  logic [WIDTH-1:0]                 y,
  input  logic                             signed_mode,
  input  logic [CONTROL_SIGNALS_WIDTH-1:0] control_signals_in,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [2*WIDTH-1:0]               result,
  output logic [CONTROL_SIGNALS_WIDTH-1:0] control_signals_out,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [$clog2((WIDTH+ROWS_PER_STAGE-2)/ROWS_PER_STAGE+2)-1:0] occupancy
);
  localparam int NCS   = (WIDTH + ROWS_PER_STAGE - 2) / ROWS_PER_STAGE;
  localparam int OCC_W = $clog2(NCS + 2);
  localparam int CW    = CONTROL_SIGNALS_WIDTH;

  logic [NCS:0]                vld_pipe;
  logic [NCS:0][2*WIDTH-1:0]   s_p, c_p;
  logic [NCS:0][WIDTH-1:0]     x_p, y_p;
  logic [NCS:0]                m_p;
  logic [NCS:0][CW-1:0]        ctl_p;
  logic [2*WIDTH-1:0]          bw_k;
  logic                        advance, accept, retire;
  logic                        unused_tail;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;
  assign retire   = out_valid && out_ready;

  // Baugh-Wooley correction constants seed the sum vector of the first stage.
  always_comb begin
    bw_k = '0;
    if (signed_mode) begin
      bw_k[WIDTH]       = 1'b1;
      bw_k[2*WIDTH-1]   = 1'b1;
    end
  end

  assign vld_pipe[0] = in_valid;
  assign s_p[0]      = bw_k;
  assign c_p[0]      = '0;
  assign x_p[0]      = x;
  assign y_p[0]      = y;
  assign m_p[0]      = signed_mode;
  assign ctl_p[0]    = control_signals_in;

  for (genvar k = 0; k < NCS; k++) begin : g_stage
    localparam int LO = (k == 0) ? 0 : k*ROWS_PER_STAGE + 1;
    localparam int HI = ((k+1)*ROWS_PER_STAGE > WIDTH-1) ? WIDTH-1 : (k+1)*ROWS_PER_STAGE;
    array_mult_pipelined_hs_stage #(.WIDTH(WIDTH), .CW(CW), .LO(LO), .HI(HI)) u_stage (
      .clk(clk), .rst(rst), .en(advance),
      .vld_i(vld_pipe[k]), .s_i(s_p[k]), .c_i(c_p[k]), .x_i(x_p[k]), .y_i(y_p[k]),
      .m_i(m_p[k]), .ctl_i(ctl_p[k]),
      .vld_o(vld_pipe[k+1]), .s_o(s_p[k+1]), .c_o(c_p[k+1]), .x_o(x_p[k+1]),
      .y_o(y_p[k+1]), .m_o(m_p[k+1]), .ctl_o(ctl_p[k+1])
    );
  end

  // Operands are fully consumed by the last carry-save stage.
  assign unused_tail = ^{x_p[NCS], y_p[NCS], m_p[NCS]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid           <= 1'b0;
      result              <= '0;
      control_signals_out <= '0;
      occupancy           <= '0;
    end else begin
      if (advance) begin
        out_valid           <= vld_pipe[NCS];
        result              <= s_p[NCS] + c_p[NCS];
        control_signals_out <= ctl_p[NCS];
      end
      if (accept && !retire)
        occupancy <= occupancy + OCC_W'(1);
      else if (retire && !accept)
        occupancy <= occupancy - OCC_W'(1);
    end
  end
endmodule

// File: tb/tb_array_mult_pipelined_hs.sv
// Randomized + directed bench for array_mult_pipelined_hs (WIDTH=8, ROWS_PER_STAGE=2, LAT=5).
// Reference: slot-per-stage pipe of plain-arithmetic products with full-freeze advance.

module tb_array_mult_pipelined_hs;
  localparam int LAT = 5;

  logic        clk = 1'b0, rst = 1'b1;
  logic [7:0]  x, y;
  logic        sm, iv, ordy, in_ready, ov;
  logic [3:0]  ci, co;
  logic [15:0] res;
  logic [2:0]  occ;

  typedef struct { logic v; logic [15:0] p; logic [3:0] c; } slot_t;
  slot_t       pipe [LAT];
  int          n_chk = 0, n_fail = 0, tick = 0, max_occ = 0, lat, acc_n;
  logic [15:0] got_q[$];
  logic [3:0]  got_c[$];
  int          got_t[$];
  logic        a_f, s_f;
  logic [7:0]  ex_x [4] = '{8'h80, 8'hFF, 8'h80, 8'h80};
  logic [7:0]  ex_y [4] = '{8'h80, 8'h7F, 8'h7F, 8'h80};
  logic        ex_m [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  logic [15:0] ex_r [4] = '{16'h4000, 16'hFF81, 16'hC080, 16'h4000};

  array_mult_pipelined_hs #(.WIDTH(8), .ROWS_PER_STAGE(2), .CONTROL_SIGNALS_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .signed_mode(sm), .control_signals_in(ci),
    .in_valid(iv), .in_ready(in_ready), .result(res), .control_signals_out(co),
    .out_valid(ov), .out_ready(ordy), .occupancy(occ)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (tick %0d)", tag, got, exp, tick);
    end
  endtask

  function automatic logic [15:0] golden(input logic [7:0] a, input logic [7:0] b, input logic m);
    logic signed [15:0] sp;
    if (m) begin
      sp = $signed(a) * $signed(b);
      return sp;
    end
    return {8'h00, a} * {8'h00, b};
  endfunction

  function automatic int model_cnt();
    int n = 0;
    for (int i = 0; i < LAT; i++) if (pipe[i].v) n++;
    return n;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < LAT; i++) pipe[i] = '{1'b0, 16'h0, 4'h0};
  endtask

  // Called at a falling edge: drive, check, let one rising edge happen, update the model.
  task automatic cycle(input logic v, input logic [7:0] a, input logic [7:0] b, input logic m,
                       input logic [3:0] c, input logic r, output logic acc, output logic seen);
    logic adv;
    iv = v; x = a; y = b; sm = m; ci = c; ordy = r;
    #1;
    check("out_valid", ov, pipe[LAT-1].v);
    if (pipe[LAT-1].v) begin
      check("result", res, pipe[LAT-1].p);
      check("ctrl", co, pipe[LAT-1].c);
    end
    adv = !pipe[LAT-1].v || r;
    check("in_ready", in_ready, adv);
    check("occupancy", occ, model_cnt());
    if (int'(occ) > max_occ) max_occ = occ;
    seen = ov;
    acc  = v && adv;
    if (ov && r) begin
      got_q.push_back(res); got_c.push_back(co); got_t.push_back(tick);
    end
    @(posedge clk);
    if (adv) begin
      for (int i = LAT-1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = '{v, golden(a, b, m), c};
    end
    tick++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h0, 8'h0, 1'b0, 4'h0, 1'b1, a_f, s_f);
  endtask

  // Count idle cycles until a result shows up, bounded.
  task automatic measure_lat(output int l);
    l = 0; s_f = 1'b0;
    while (!s_f && l < 20) begin
      cycle(1'b0, 8'h0, 8'h0, 1'b0, 4'h0, 1'b1, a_f, s_f);
      l++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_out_valid", ov, 1'b0);
    check("rst_occupancy", occ, 3'd0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_result", res, 16'h0);
    check("rst_ctrl", co, 4'h0);
    clear_model();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    iv = 0; x = 0; y = 0; sm = 0; ci = 0; ordy = 1;
    clear_model();
    repeat (2) @(negedge clk);
    do_reset();

    // Unsigned extremes
    got_q.delete(); got_c.delete(); got_t.delete();
    cycle(1'b1, 8'hFF, 8'hFF, 1'b0, 4'hA, 1'b1, a_f, s_f);
    check("ext_accept", a_f, 1'b1);
    measure_lat(lat);
    check("ext_latency", lat, LAT);
    check("ext_count", got_q.size(), 1);
    if (got_q.size() > 0) begin
      check("ext_result", got_q[0], 16'hFE01);
      check("ext_ctrl", got_c[0], 4'hA);
    end
    idle(1);
    check("ext_occ_zero", occ, 3'd0);

    // Signed corners back-to-back
    got_q.delete(); got_c.delete(); got_t.delete();
    for (int i = 0; i < 4; i++) cycle(1'b1, ex_x[i], ex_y[i], ex_m[i], 4'(i), 1'b1, a_f, s_f);
    idle(8);
    check("corner_count", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      check("corner_result", got_q[i], ex_r[i]);
      if (i > 0) check("corner_spacing", got_t[i] - got_t[i-1], 1);
    end

    // Backpressure: freeze from cycle 3 for 6 cycles
    got_q.delete(); got_c.delete(); got_t.delete();
    max_occ = 0;
    begin
      int idx = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
        cycle(idx < 8, 8'(idx*17 + 3), 8'(idx*29 + 1), idx[0], 4'(idx),
              !(cyc >= 3 && cyc < 9), a_f, s_f);
        if (a_f) idx++;
      end
      check("bp_accepted", idx, 8);
    end
    check("bp_max_occ", max_occ, LAT);
    check("bp_count", got_q.size(), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      check("bp_result", got_q[i], golden(8'(i*17 + 3), 8'(i*29 + 1), i[0]));
      check("bp_ctrl", got_c[i], 4'(i));
    end

    // Bubbles
    got_q.delete(); got_c.delete(); got_t.delete();
    cycle(1'b1, 8'd3, 8'd5, 1'b0, 4'h1, 1'b1, a_f, s_f);
    cycle(1'b0, 8'd0, 8'd0, 1'b0, 4'h0, 1'b1, a_f, s_f);
    cycle(1'b1, 8'd7, 8'd9, 1'b0, 4'h2, 1'b1, a_f, s_f);
    cycle(1'b0, 8'd0, 8'd0, 1'b0, 4'h0, 1'b1, a_f, s_f);
    idle(6);
    check("bub_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("bub_res0", got_q[0], 16'h000F);
      check("bub_res1", got_q[1], 16'h003F);
      check("bub_gap", got_t[1] - got_t[0], 2);
    end

    // Reset mid-flight
    got_q.delete(); got_c.delete(); got_t.delete();
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(i+1), 8'(i+2), 1'b0, 4'h3, 1'b1, a_f, s_f);
    do_reset();
    idle(8);
    check("rstmid_no_output", got_q.size(), 0);
    check("rstmid_occ", occ, 3'd0);
    cycle(1'b1, 8'd2, 8'd3, 1'b0, 4'h5, 1'b1, a_f, s_f);
    measure_lat(lat);
    check("rstmid_latency", lat, LAT);
    check("rstmid_count", got_q.size(), 1);
    if (got_q.size() > 0) check("rstmid_result", got_q[0], 16'h0006);

    // Randomized
    got_q.delete(); got_c.delete(); got_t.delete();
    acc_n = 0;
    for (int i = 0; i < 10000; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 1'($urandom),
            4'($urandom), 1'($urandom_range(0, 3) != 0), a_f, s_f);
      if (a_f) acc_n++;
    end
    idle(LAT + 3);
    check("rand_all_retired", got_q.size(), acc_n);
    check("rand_occ_zero", occ, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/array_mult_pipelined_hs.md
Name: array_mult_pipelined_hs

Overview:
- Next-generation pipelined array multiplier for the FIR datapath. Replaces the fixed one-row-per-stage multiplier.
- Adds a configurable rows-per-stage register grouping and a per-transaction signed/unsigned mode using Baugh-Wooley sign handling.
- Adds a valid/ready handshake with backpressure, plus a sideband control field that travels with each product.
- Sits between the coefficient/sample fetch logic and the FIR accumulator.

Parameters:
- WIDTH, 8, operand width in bits (>=2).
- ROWS_PER_STAGE, 1, partial-product adder rows between pipeline registers (1..WIDTH-1).
- CONTROL_SIGNALS_WIDTH, 4, sideband bits carried alongside each operand pair.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- x  input  WIDTH  multiplicand.
- y  input  WIDTH  multiplier.
- signed_mode  input  1  1 = two's-complement operands and product; 0 = unsigned.
- control_signals_in  input  CONTROL_SIGNALS_WIDTH  sideband, captured with x/y.
- in_valid  input  1  x, y, signed_mode and control_signals_in are valid.
- in_ready  output  1  block can accept an input this cycle.
- result  output  2*WIDTH  product.
- control_signals_out  output  CONTROL_SIGNALS_WIDTH  sideband matching result.
- out_valid  output  1  result and control_signals_out are valid.
- out_ready  input  1  downstream accepts the result.
- occupancy  output  $clog2(LAT+1)  number of transactions in flight.

Behaviour:
- One clock domain. rst is asynchronous and active-high.
- Latency:
  - LAT = ceil((WIDTH-1)/ROWS_PER_STAGE) + 1.
  - The carry-save row stages come first; the last stage is a registered carry-propagate adder.
  - Example: WIDTH=8, ROWS_PER_STAGE=2 gives LAT=5.
- Each stage register holds: partial sum, carry vector, remaining operand bits, signed_mode, control bits, and a valid bit.
- Global advance: advance = !out_valid || out_ready.
  - When advance=1, all stages shift by one.
  - When advance=0, every stage holds (full freeze; no bubble collapsing).
- in_ready = advance (combinational).
- Input capture:
  - A transaction is accepted when in_valid && in_ready.
  - If in_valid=0 while advancing, a bubble (valid=0) enters stage 0.
- Output:
  - out_valid is the valid bit of the last stage.
  - result and control_signals_out are the last-stage registers.
  - Their values are don't-care while out_valid=0, but they must hold stable while out_valid=1 && out_ready=0.
- Arithmetic:
  - signed_mode=0: result = x*y, unsigned, exact in 2*WIDTH bits.
  - signed_mode=1: result = x*y in two's complement, exact in 2*WIDTH bits. Use Baugh-Wooley: invert the MSB-row/MSB-column partial products, add the constant 1 at bit WIDTH and at bit 2*WIDTH-1, discard carry-out.
  - Mode is per transaction and carried down the pipe. Back-to-back mixed modes are legal.
- occupancy:
  - Increments on accept without retire.
  - Decrements on retire (out_valid && out_ready) without accept.
  - Unchanged when both or neither occur.
  - Never exceeds LAT.
- Reset values: all stage valid bits 0, out_valid=0, result=0, control_signals_out=0, occupancy=0. in_ready=1 after reset (since out_valid=0).
- Reset mid-operation: all in-flight transactions are discarded with no output. The first accept after reset release produces its result LAT cycles later.
- Throughput: one result per cycle when out_ready is held high.
- Boundary conditions:
  - Full pipe with out_ready=0: in_ready=0 and the input is not captured, even if in_valid=1.
  - Retire and accept in the same cycle are permitted.

Test Plan (WIDTH=8, ROWS_PER_STAGE=2, LAT=5):
- Unsigned extremes, out_ready=1: x=0xFF, y=0xFF, signed_mode=0, control_signals_in=0xA, accepted at cycle T -> out_valid=1 at T+5, result=0xFE01, control_signals_out=0xA, occupancy back to 0 the following cycle.
- Signed corners, back-to-back every cycle:
  - (-128)*(-128) -> 0x4000
  - (-1)*127 -> 0xFF81
  - (-128)*127 -> 0xC080
  - 0x80*0x80 unsigned -> 0x4000
  - Required: results in order on consecutive cycles with no bubbles.
- Backpressure: stream 8 transactions; hold out_ready=0 from cycle 3 for 6 cycles -> pipe fills; occupancy saturates at 5; in_ready=0; result held stable. After release, all 8 results appear in order with none lost or duplicated.
- Bubbles: in_valid pattern 1,0,1,0 with operands 3*5 and 7*9 -> out_valid pattern 1,0,1,0 with results 0x000F and 0x003F.
- Reset mid-flight: accept 3 transactions, assert rst for 1 cycle at cycle 2 -> out_valid never asserts for them; occupancy=0. A new 2*3 accepted after reset gives 0x0006 at +5 cycles.
- Randomized check: 10k random x, y and mode with random out_ready -> every result matches a golden model, sideband matches, and occupancy equals the scoreboard count.
